ssd1306_seq: RTL and testbench
==============================

SSD1306_SEQ -- requirements
Module: ssd1306_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning sequence ROM address width.
REQ-002 SHALL have parameter SEQ_NUM, default 4, meaning number of selectable sequences (1..16).
REQ-003 SHALL have parameter ENTRY_TABLE, default {7'd96,7'd80,7'd64,7'd0}, meaning SEQ_NUM packed ADDR_W-bit start addresses, with sequence 0 in the LSBs.
REQ-004 SHALL have parameter DELAY_SHIFT, default 13, meaning the left shift applied to the 4-bit delay operand.
REQ-005 SHALL have parameter WAIT_TIMEOUT, default 4095, meaning maximum clk_in cycles spent in S_SEND plus S_WAIT; 0 disables the timeout.
REQ-006 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_in, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port seq_start, input, 1 bit: one-cycle request to run sequence seq_id.
REQ-009 SHALL have port seq_id, input, 4 bits: sequence index, sampled with seq_start.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not S_IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on a STOP retire.
REQ-012 SHALL have port error, output, 1 bit: sticky fault flag, cleared by reset or an accepted seq_start.
REQ-013 SHALL have port rom_address, output, ADDR_W bits: ROM address, registered.
REQ-014 SHALL have port rom_data, input, 11 bits: [10] dc, [9] local, [8] last, [7:0] byte; ROM read latency is exactly 1 cycle.
REQ-015 SHALL have ports command_start (output, 1), command_out (output, 8), command_last_byte (output, 1) and command_ready (input, 1), forming the shift-register handshake.
REQ-016 SHALL have ports oled_rstn, oled_vbatn and oled_dc, all output, 1 bit each, all registered.

Function
REQ-017 SHALL implement the states S_IDLE, S_FETCH, S_EXEC, S_DELAY, S_SEND, S_WAIT, S_RETIRE and S_ERROR.
REQ-018 SHALL behave as follows in S_IDLE: on seq_start with seq_id<SEQ_NUM, load rom_address from the ENTRY_TABLE slot, clear error, and go to S_FETCH; on seq_id>=SEQ_NUM, set error and stay in S_IDLE.
REQ-019 SHALL ignore seq_start whenever busy=1; there is no queueing.
REQ-020 SHALL use S_FETCH as a single wait cycle for ROM latency and then go to S_EXEC.
REQ-021 SHALL, in S_EXEC with local=0, register oled_dc<=rom_data[10], latch command_out and command_last_byte, and go to S_SEND if command_ready=1, otherwise wait in S_EXEC.
REQ-022 SHALL, in S_EXEC with local=1, decode opcode byte[7:4]: 0x1 sets oled_rstn<=byte[0]; 0x2 sets oled_vbatn<=byte[0]; 0x3 loads the delay counter with byte[3:0]<<DELAY_SHIFT and goes to S_DELAY; 0xF is STOP; any other opcode sets error and goes to S_ERROR.
REQ-023 SHALL, in S_DELAY, decrement the counter and go to S_RETIRE in the cycle where the counter equals 0, so total delay cycles = value+1; a zero operand gives a 1-cycle delay.
REQ-024 SHALL, in S_SEND, hold command_start=1 until command_ready=0 and then go to S_WAIT; in S_WAIT, go to S_RETIRE when command_ready=1.
REQ-025 SHALL count cycles from S_SEND entry while WAIT_TIMEOUT!=0; when the count reaches WAIT_TIMEOUT, set error, force command_start=0, and go to S_ERROR.
REQ-026 SHALL, in S_RETIRE for a non-STOP entry, increment rom_address and go to S_FETCH; for STOP, pulse done and go to S_IDLE.
REQ-027 SHALL treat wrap-around as a fault: if the increment would wrap rom_address from all-ones to 0, set error and go to S_ERROR instead.
REQ-028 SHALL leave S_ERROR for S_IDLE on the next cycle, keeping error=1, oled_rstn and oled_vbatn unchanged, and busy=0 once in S_IDLE.
REQ-029 SHALL drive command_start only in S_SEND and SHALL keep command_out and command_last_byte stable from S_EXEC through S_WAIT.

Reset
REQ-030 SHALL, while reset_in=1, set oled_rstn=0, oled_vbatn=1, oled_dc=0, command_start=0, done=0, error=0 and the delay and timeout counters to 0.
REQ-031 SHALL, while reset_in=1, load rom_address from the ENTRY_TABLE slot for sequence 0 and set the state to S_FETCH, so sequence 0 runs automatically after reset with busy=1 from the first post-reset cycle.
REQ-032 SHALL, on reset asserted mid-operation in any state, abort within the same cycle, with no done pulse and command_start=0 on the next edge.

Verification
REQ-033 SHALL be verified by a reset-then-sequence-0 scenario: ROM[0..3] = {RST 1, DELAY 0, byte 0xAE, STOP} with command_ready returning 3 cycles after start -> oled_rstn rises, exactly one command_start burst with command_out=0xAE and dc=0, then a done pulse.
REQ-034 SHALL be verified by a delay-accuracy scenario: DELAY 2 with DELAY_SHIFT=4 -> exactly 33 cycles spent in S_DELAY.
REQ-035 SHALL be verified by a timeout scenario: WAIT_TIMEOUT=10 with command_ready held 0 after start -> error=1 after the 10th cycle, busy=0, and done never pulsed.
REQ-036 SHALL be verified by a selection scenario: seq_start with seq_id=2 -> rom_address=96; seq_start with seq_id=5 while SEQ_NUM=4 -> error=1 and busy stays 0.
REQ-037 SHALL be verified by an abort scenario: reset asserted during S_WAIT -> outputs take their REQ-030 values and sequence 0 restarts at its entry address.
REQ-038 SHALL be verified by a wrap scenario: a final non-STOP entry at address 127 -> error=1 and no fetch from address 0.

Source files
------------

// File: rtl/ssd1306_seq_if.sv
// ssd1306_seq_if: sequence ROM read port plus command shift-register handshake
//   rom_address       sequencer -> ROM, registered address
//   rom_data          ROM -> sequencer, {dc, local, last, byte}, 1-cycle latency
//   command_start     sequencer -> shifter, held while a byte is being handed over
//   command_out       sequencer -> shifter, byte to shift
//   command_last_byte sequencer -> shifter, last byte of a transfer
//   command_ready     shifter -> sequencer, idle/accepting
interface ssd1306_seq_if #(
   parameter int ADDR_W = 7
);
   logic [ADDR_W-1:0] rom_address;
   logic [10:0]       rom_data;
   logic              command_start;
   logic [7:0]        command_out;
   logic              command_last_byte;
   logic              command_ready;
   modport master (
      output rom_address, command_start, command_out, command_last_byte,
      input  rom_data, command_ready
   );
   modport slave (
      input  rom_address, command_start, command_out, command_last_byte,
      output rom_data, command_ready
   );
endinterface

// File: rtl/ssd1306_seq.sv
// ssd1306_seq: ROM-driven SSD1306 power-up/command sequencer
//   clk_in, reset_in  clock and synchronous active-high reset
//   seq_start, seq_id request to run one of SEQ_NUM ROM sequences
//   busy, done, error sequencer status (done pulses on STOP, error is sticky)
//   oled_*            registered panel reset, VBAT enable and data/command select
//   bus               ROM read port and command shift-register handshake
module ssd1306_seq #(
   parameter int                          ADDR_W       = 7,
   parameter int                          SEQ_NUM      = 4,
   parameter logic [SEQ_NUM*ADDR_W-1:0]   ENTRY_TABLE  = {7'd96, 7'd80, 7'd64, 7'd0},
   parameter int                          DELAY_SHIFT  = 13,
   parameter int                          WAIT_TIMEOUT = 4095
) (
   input  logic          clk_in,
   input  logic          reset_in,
   input  logic          seq_start,
   input  logic [3:0]    seq_id,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic          oled_rstn,
   output logic          oled_vbatn,
   output logic          oled_dc,
   ssd1306_seq_if.master bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_DELAY  = 3'd3;
   localparam logic [2:0] S_SEND   = 3'd4;
   localparam logic [2:0] S_WAIT   = 3'd5;
   localparam logic [2:0] S_RETIRE = 3'd6;
   localparam logic [2:0] S_ERROR  = 3'd7;
   localparam int DW = 4 + DELAY_SHIFT;
   localparam int TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

   logic [2:0]                state_q, state_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic                      rstn_q, rstn_d, vbatn_q, vbatn_d, dc_q, dc_d;
   logic [7:0]                out_q, out_d;
   logic                      last_q, last_d, err_q, err_d, stop_q, stop_d;
   logic                      start_q, done_q;
   logic [DW-1:0]             dly_q, dly_d;
   logic [TW-1:0]             tmo_q, tmo_d;
   logic [SEQ_NUM*ADDR_W-1:0] tbl;
   logic                      rom_local;
   logic [3:0]                rom_op;
   logic [7:0]                rom_byte;

   assign tbl       = ENTRY_TABLE >> (ADDR_W * 32'(seq_id));
   assign rom_local = bus.rom_data[9];
   assign rom_byte  = bus.rom_data[7:0];
   assign rom_op    = rom_byte[7:4];

   assign busy                  = state_q != S_IDLE;
   assign done                  = done_q;
   assign error                 = err_q;
   assign oled_rstn             = rstn_q;
   assign oled_vbatn            = vbatn_q;
   assign oled_dc               = dc_q;
   assign bus.rom_address       = addr_q;
   assign bus.command_start     = start_q;
   assign bus.command_out       = out_q;
   assign bus.command_last_byte = last_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rstn_d  = rstn_q;
      vbatn_d = vbatn_q;
      dc_d    = dc_q;
      out_d   = out_q;
      last_d  = last_q;
      err_d   = err_q;
      stop_d  = stop_q;
      dly_d   = dly_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (seq_start && 32'(seq_id) < SEQ_NUM) begin
               addr_d  = tbl[ADDR_W-1:0];
               err_d   = 1'b0;
               state_d = S_FETCH;
            end else if (seq_start) begin
               err_d = 1'b1;
            end
         end
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            stop_d = 1'b0;
            tmo_d  = '0;
            if (!rom_local) begin
               dc_d    = bus.rom_data[10];
               out_d   = rom_byte;
               last_d  = bus.rom_data[8];
               state_d = bus.command_ready ? S_SEND : S_EXEC;
            end else begin
               state_d = S_RETIRE;
               case (rom_op)
                  4'h1: rstn_d = rom_byte[0];
                  4'h2: vbatn_d = rom_byte[0];
                  4'h3: begin
                     dly_d   = DW'(rom_byte[3:0]) << DELAY_SHIFT;
                     state_d = S_DELAY;
                  end
                  4'hF: stop_d = 1'b1;
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_ERROR;
                  end
               endcase
            end
         end
         S_DELAY: begin
            dly_d   = (dly_q == '0) ? dly_q : dly_q - 1'b1;
            state_d = (dly_q == '0) ? S_RETIRE : S_DELAY;
         end
         S_SEND, S_WAIT: begin
            tmo_d = tmo_q + 1'b1;
            // timeout takes priority so SEND+WAIT never exceeds WAIT_TIMEOUT cycles
            if (WAIT_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end else if (state_q == S_SEND && !bus.command_ready) begin
               state_d = S_WAIT;
            end else if (state_q == S_WAIT && bus.command_ready) begin
               state_d = S_RETIRE;
            end
         end
         S_RETIRE: begin
            if (stop_q) begin
               state_d = S_IDLE;
            end else if (&addr_q) begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // command_start follows the next state so it is high exactly while in S_SEND
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q <= S_FETCH;
         addr_q  <= ENTRY_TABLE[ADDR_W-1:0];
         rstn_q  <= 1'b0;
         vbatn_q <= 1'b1;
         dc_q    <= 1'b0;
         out_q   <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         stop_q  <= 1'b0;
         dly_q   <= '0;
         tmo_q   <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rstn_q  <= rstn_d;
         vbatn_q <= vbatn_d;
         dc_q    <= dc_d;
         out_q   <= out_d;
         last_q  <= last_d;
         err_q   <= err_d;
         stop_q  <= stop_d;
         dly_q   <= dly_d;
         tmo_q   <= tmo_d;
         start_q <= state_d == S_SEND;
         done_q  <= state_q == S_RETIRE && stop_q;
      end
   end
endmodule

// File: tb/tb_ssd1306_seq.sv
// tb_ssd1306_seq: directed bench for ssd1306_seq with a ROM and a shifter responder
module tb_ssd1306_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       seq_start = 1'b0;
   logic [3:0] seq_id = 4'd0;
   logic       busy, done, error, oled_rstn, oled_vbatn, oled_dc;
   logic       rdy = 1'b1;
   logic       no_return = 1'b0;
   logic       watch0 = 1'b0;
   int         rcnt = 0;
   int         passed = 0;
   int         total = 0;
   int         cyc = 0, bursts = 0, dones = 0, delays = 0, addr0 = 0;
   int         start_cyc = 0, err_cyc = 0;
   logic [7:0] cap_out = '0;
   logic       cap_dc = 1'b0, cap_last = 1'b0, prev_start = 1'b0, prev_err = 1'b0;
   logic [10:0] rom [128];
   int         b0, d0, t0;

   ssd1306_seq_if #(.ADDR_W(7)) bus ();

   ssd1306_seq #(
      .ADDR_W(7), .SEQ_NUM(4), .ENTRY_TABLE({7'd127, 7'd96, 7'd64, 7'd0}),
      .DELAY_SHIFT(4), .WAIT_TIMEOUT(10)
   ) dut (
      .clk_in(clk), .reset_in(rst), .seq_start(seq_start), .seq_id(seq_id),
      .busy(busy), .done(done), .error(error), .oled_rstn(oled_rstn),
      .oled_vbatn(oled_vbatn), .oled_dc(oled_dc), .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.command_ready = rdy;

   always @(posedge clk) bus.rom_data <= rom[bus.rom_address];

   // shifter: drops ready on a start, raises it again 3 cycles later unless held off
   always @(posedge clk) begin
      if (bus.command_start && rdy) begin
         rdy  <= 1'b0;
         rcnt <= 3;
      end else if (rcnt != 0) begin
         rcnt <= rcnt - 1;
         if (rcnt == 1 && !no_return) rdy <= 1'b1;
      end else if (!rdy && !no_return) begin
         rdy <= 1'b1;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.command_start && !prev_start) begin
         bursts    <= bursts + 1;
         cap_out   <= bus.command_out;
         cap_dc    <= oled_dc;
         cap_last  <= bus.command_last_byte;
         start_cyc <= cyc;
      end
      if (error && !prev_err) err_cyc <= cyc;
      if (done) dones <= dones + 1;
      if (dut.state_q == 3'd3) delays <= delays + 1;
      if (watch0 && busy && bus.rom_address == 7'd0) addr0 <= addr0 + 1;
      prev_start <= bus.command_start;
      prev_err   <= error;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      else passed++;
   endtask

   task automatic start_seq(input logic [3:0] id);
      seq_id    = id;
      seq_start = 1'b1;
      @(negedge clk);
      seq_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = 11'h2F0;
      rom[0]   = 11'h211;
      rom[1]   = 11'h230;
      rom[2]   = 11'h1AE;
      rom[3]   = 11'h2F0;
      rom[64]  = 11'h220;
      rom[65]  = 11'h232;
      rom[66]  = 11'h2F0;
      rom[96]  = 11'h4AF;
      rom[97]  = 11'h2F0;
      rom[127] = 11'h220;

      repeat (3) @(negedge clk);
      check("rst_rstn", 32'(oled_rstn), 32'd0);
      check("rst_vbatn", 32'(oled_vbatn), 32'd1);
      check("rst_dc", 32'(oled_dc), 32'd0);
      check("rst_start", 32'(bus.command_start), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_addr", 32'(bus.rom_address), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;

      wait_idle("seq0");
      check("seq0_bursts", 32'(bursts), 32'd1);
      check("seq0_out", 32'(cap_out), 32'hAE);
      check("seq0_dc", 32'(cap_dc), 32'd0);
      check("seq0_last", 32'(cap_last), 32'd1);
      check("seq0_done", 32'(dones), 32'd1);
      check("seq0_rstn", 32'(oled_rstn), 32'd1);
      check("seq0_error", 32'(error), 32'd0);

      d0 = dones;
      start_seq(4'd1);
      wait_idle("dly");
      check("dly_cycles", 32'(delays), 32'd34);
      check("dly_vbatn", 32'(oled_vbatn), 32'd0);
      check("dly_done", 32'(dones - d0), 32'd1);

      b0 = bursts;
      d0 = dones;
      start_seq(4'd2);
      check("sel2_addr", 32'(bus.rom_address), 32'd96);
      check("sel2_busy", 32'(busy), 32'd1);
      wait_idle("sel2");
      check("sel2_bursts", 32'(bursts - b0), 32'd1);
      check("sel2_out", 32'(cap_out), 32'hAF);
      check("sel2_dc", 32'(cap_dc), 32'd1);
      check("sel2_done", 32'(dones - d0), 32'd1);

      start_seq(4'd5);
      check("sel5_error", 32'(error), 32'd1);
      check("sel5_busy", 32'(busy), 32'd0);

      no_return = 1'b1;
      b0 = bursts;
      d0 = dones;
      start_seq(4'd2);
      check("tmo_cleared", 32'(error), 32'd0);
      wait_idle("tmo");
      check("tmo_error", 32'(error), 32'd1);
      check("tmo_busy", 32'(busy), 32'd0);
      check("tmo_start", 32'(bus.command_start), 32'd0);
      check("tmo_done", 32'(dones - d0), 32'd0);
      check("tmo_bursts", 32'(bursts - b0), 32'd1);
      check("tmo_cycles", 32'(err_cyc - start_cyc), 32'd10);
      no_return = 1'b0;
      repeat (3) @(negedge clk);

      no_return = 1'b1;
      d0 = dones;
      start_seq(4'd2);
      t0 = 0;
      while (!bus.command_start && t0 < 50) begin
         @(negedge clk);
         t0++;
      end
      repeat (4) @(negedge clk);
      check("abort_in_wait", 32'({busy, bus.command_start}), 32'b10);
      rst = 1'b1;
      @(negedge clk);
      check("abort_rstn", 32'(oled_rstn), 32'd0);
      check("abort_vbatn", 32'(oled_vbatn), 32'd1);
      check("abort_dc", 32'(oled_dc), 32'd0);
      check("abort_start", 32'(bus.command_start), 32'd0);
      check("abort_error", 32'(error), 32'd0);
      check("abort_addr", 32'(bus.rom_address), 32'd0);
      check("abort_busy", 32'(busy), 32'd1);
      no_return = 1'b0;
      @(negedge clk);
      check("abort_nodone", 32'(dones - d0), 32'd0);
      rst = 1'b0;
      b0 = bursts;
      wait_idle("rerun");
      check("rerun_done", 32'(dones - d0), 32'd1);
      check("rerun_out", 32'(cap_out), 32'hAE);
      check("rerun_bursts", 32'(bursts - b0), 32'd1);
      check("rerun_rstn", 32'(oled_rstn), 32'd1);

      d0 = dones;
      start_seq(4'd3);
      watch0 = 1'b1;
      wait_idle("wrap");
      check("wrap_error", 32'(error), 32'd1);
      check("wrap_addr", 32'(bus.rom_address), 32'd127);
      check("wrap_vbatn", 32'(oled_vbatn), 32'd0);
      check("wrap_nofetch0", 32'(addr0), 32'd0);
      check("wrap_done", 32'(dones - d0), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
